// File: rtl/regfile_bist_seq_if.sv
// Register-file bus between the BIST sequencer and the 32x32 2R/1W register file.
//   master : sequencer side, drives write port and both read addresses
//   slave  : register-file side, returns combinational read data
// Signals:
//   W_Addr, W_Data, Write_Reg  write port
//   R_Addr_A, R_Addr_B         read port addresses
//   R_Data_A, R_Data_B         read port data (combinational in the register file)
interface regfile_bist_seq_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] W_Addr;
   logic [DATA_W-1:0] W_Data;
   logic              Write_Reg;
   logic [ADDR_W-1:0] R_Addr_A;
   logic [ADDR_W-1:0] R_Addr_B;
   logic [DATA_W-1:0] R_Data_A;
   logic [DATA_W-1:0] R_Data_B;

   modport master (
      output W_Addr, W_Data, Write_Reg, R_Addr_A, R_Addr_B,
      input  R_Data_A, R_Data_B
   );

   modport slave (
      input  W_Addr, W_Data, Write_Reg, R_Addr_A, R_Addr_B,
      output R_Data_A, R_Data_B
   );
endinterface

// File: rtl/regfile_bist_seq.sv
// Built-in self test sequencer for the 2R/1W register file.
// On start it writes pat(a) = SEED + a*STEP to every entry, then reads every
// entry back on both ports (A ascending, B descending) and compares.
// Ports:
//   clk        rising-edge clock
//   Reset      asynchronous active-low reset
//   start      begin a run; honoured only in IDLE or DONE
//   busy       high while writing or reading
//   done       high in DONE
//   pass       valid with done; 1 = no mismatch seen
//   err_addr   address of the first mismatch of the run (0 if none)
//   err_count  number of mismatching port reads
//   rf         register-file bus (master side)
//
// state   | meaning
// S_IDLE  | waiting for start after reset
// S_WRITE | writing pat(cnt) to entry cnt
// S_READ  | port A reads cnt, port B reads DEPTH-1-cnt, both compared
// S_DONE  | results held until the next start
module regfile_bist_seq #(
   parameter int                 ADDR_W = 5,
   parameter int                 DATA_W = 32,
   parameter logic [DATA_W-1:0]  SEED   = 32'h1234_5678,
   parameter logic [DATA_W-1:0]  STEP   = 32'h0001_0001
) (
   input  logic                clk,
   input  logic                Reset,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [ADDR_W-1:0]   err_addr,
   output logic [ADDR_W+1:0]   err_count,
   regfile_bist_seq_if.master  rf
);

   localparam logic [ADDR_W-1:0] LAST     = '1;
   localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
   localparam logic [DATA_W-1:0] PAT_LAST = SEED + DATA_W'(2**ADDR_W - 1) * STEP;

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] cnt;
   // Running patterns: pat_a tracks pat(cnt), pat_b tracks pat(DEPTH-1-cnt),
   // so no multiplier is needed.
   logic [DATA_W-1:0] pat_a;
   logic [DATA_W-1:0] pat_b;

   logic              a_fail;
   logic              b_fail;
   logic [ADDR_W+1:0] err_next;

   always_comb begin
      a_fail   = (rf.R_Data_A != pat_a);
      b_fail   = (rf.R_Data_B != pat_b);
      err_next = err_count + (ADDR_W+2)'(a_fail) + (ADDR_W+2)'(b_fail);
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state        <= S_IDLE;
         cnt          <= '0;
         pat_a        <= '0;
         pat_b        <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
         err_addr     <= '0;
         err_count    <= '0;
         rf.Write_Reg <= 1'b0;
         rf.W_Addr    <= '0;
         rf.W_Data    <= '0;
         rf.R_Addr_A  <= '0;
         rf.R_Addr_B  <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state        <= S_WRITE;
                  cnt          <= '0;
                  pat_a        <= SEED;
                  busy         <= 1'b1;
                  done         <= 1'b0;
                  pass         <= 1'b0;
                  err_addr     <= '0;
                  err_count    <= '0;
                  rf.Write_Reg <= 1'b1;
                  rf.W_Addr    <= '0;
                  rf.W_Data    <= SEED;
               end
            end

            S_WRITE: begin
               if (cnt == LAST) begin
                  state        <= S_READ;
                  cnt          <= '0;
                  pat_a        <= SEED;
                  pat_b        <= PAT_LAST;
                  rf.Write_Reg <= 1'b0;
                  rf.W_Addr    <= '0;
                  rf.W_Data    <= '0;
                  rf.R_Addr_A  <= '0;
                  rf.R_Addr_B  <= LAST;
               end else begin
                  cnt       <= cnt + ONE;
                  pat_a     <= pat_a + STEP;
                  rf.W_Addr <= cnt + ONE;
                  rf.W_Data <= pat_a + STEP;
               end
            end

            S_READ: begin
               err_count <= err_next;
               // err_count still zero means no mismatch yet in this run;
               // port A has priority when both fail together.
               if (err_count == '0) begin
                  if (a_fail) begin
                     err_addr <= cnt;
                  end else if (b_fail) begin
                     err_addr <= LAST - cnt;
                  end
               end
               if (cnt == LAST) begin
                  state       <= S_DONE;
                  cnt         <= '0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  pass        <= (err_next == '0);
                  rf.R_Addr_A <= '0;
                  rf.R_Addr_B <= '0;
               end else begin
                  cnt         <= cnt + ONE;
                  pat_a       <= pat_a + STEP;
                  pat_b       <= pat_b - STEP;
                  rf.R_Addr_A <= cnt + ONE;
                  rf.R_Addr_B <= LAST - cnt - ONE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_bist_seq.sv
// Bench for regfile_bist_seq: ideal register-file model with injectable
// stuck-at-0 / bit-flip read faults, directed scenarios plus randomized faults.
module tb_regfile_bist_seq;

   localparam int          DEPTH  = 32;
   localparam logic [31:0] SEED_A = 32'h1234_5678;
   localparam logic [31:0] SEED_B = 32'hFFFF_FFFF;
   localparam logic [31:0] STEP   = 32'h0001_0001;

   logic clk;
   logic Reset;
   logic start;
   logic start2;

   logic       busy, done, pass;
   logic [4:0] err_addr;
   logic [6:0] err_count;
   logic       busy2, done2, pass2;
   logic [4:0] err_addr2;
   logic [6:0] err_count2;

   int checks;
   int errors;

   logic [31:0] mem    [DEPTH];
   logic [31:0] mem2   [DEPTH];
   logic [31:0] stuck0 [DEPTH];
   logic [31:0] flip   [DEPTH];

   regfile_bist_seq_if #(.ADDR_W(5), .DATA_W(32)) rf  ();
   regfile_bist_seq_if #(.ADDR_W(5), .DATA_W(32)) rf2 ();

   regfile_bist_seq dut (
      .clk(clk), .Reset(Reset), .start(start), .busy(busy), .done(done),
      .pass(pass), .err_addr(err_addr), .err_count(err_count), .rf(rf)
   );

   regfile_bist_seq #(.SEED(SEED_B)) dut2 (
      .clk(clk), .Reset(Reset), .start(start2), .busy(busy2), .done(done2),
      .pass(pass2), .err_addr(err_addr2), .err_count(err_count2), .rf(rf2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register-file models: synchronous write, combinational read.
   always @(posedge clk) begin
      if (rf.Write_Reg)  mem[rf.W_Addr]   <= rf.W_Data;
      if (rf2.Write_Reg) mem2[rf2.W_Addr] <= rf2.W_Data;
   end
   assign rf.R_Data_A  = (mem[rf.R_Addr_A] & ~stuck0[rf.R_Addr_A]) ^ flip[rf.R_Addr_A];
   assign rf.R_Data_B  = (mem[rf.R_Addr_B] & ~stuck0[rf.R_Addr_B]) ^ flip[rf.R_Addr_B];
   assign rf2.R_Data_A = mem2[rf2.R_Addr_A];
   assign rf2.R_Data_B = mem2[rf2.R_Addr_B];

   function automatic logic [31:0] pat(input logic [31:0] seed, input int a);
      return seed + 32'(a) * STEP;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit faulty(input int a);
      logic [31:0] p;
      p = pat(SEED_A, a);
      return ((p & ~stuck0[a]) ^ flip[a]) != p;
   endfunction

   // Every entry is read once on each port, so a bad entry costs 2 mismatches.
   // The first mismatch comes from the bad entry closest to either end of the
   // address range (A walks up, B walks down); on a tie port A's address wins.
   task automatic model(output int ec, output int ea, output bit ep);
      int best;
      int rank;
      ec   = 0;
      ea   = 0;
      best = 1000;
      for (int e = 0; e < DEPTH; e++) begin
         if (faulty(e)) begin
            ec += 2;
            rank = (e < DEPTH - e) ? 2 * e : 2 * (DEPTH - 1 - e) + 1;
            if (rank < best) begin
               best = rank;
               ea   = e;
            end
         end
      end
      ep = (ec == 0);
   endtask

   task automatic clear_faults();
      for (int i = 0; i < DEPTH; i++) begin
         stuck0[i] = '0;
         flip[i]   = '0;
      end
   endtask

   // One full run on dut. pw/pr: write/read index at which a stray start pulse
   // is driven (-1 for none). hold: keep start high into the first DONE cycle.
   task automatic run_dut(input int pw, input int pr, input bit hold);
      int wn, rn, lat, ec, ea;
      bit fin, ep;
      model(ec, ea, ep);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("start_err_count", 64'(err_count), 64'd0);
      chk("start_err_addr", 64'(err_addr), 64'd0);
      chk("start_busy_done", 64'({busy, done, pass}), 64'b100);
      wn  = 0;
      rn  = 0;
      lat = 1;
      fin = 1'b0;
      for (int i = 0; i < 200 && !fin; i++) begin
         start = 1'b0;
         if (rf.Write_Reg) begin
            chk("w_addr", 64'(rf.W_Addr), 64'(wn));
            chk("w_data", 64'(rf.W_Data), 64'(pat(SEED_A, wn)));
            if (wn == 3) chk("w_data_addr3", 64'(rf.W_Data), 64'h1237_567B);
            if (wn == pw) start = 1'b1;
            wn++;
         end else if (busy) begin
            chk("r_addr", 64'({rf.R_Addr_A, rf.R_Addr_B}), 64'({5'(rn), 5'(DEPTH - 1 - rn)}));
            if (rn == pr) start = 1'b1;
            rn++;
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (done) fin = 1'b1;
      end
      start = 1'b0;
      chk("done_seen", 64'(fin), 64'd1);
      chk("latency", 64'(lat), 64'(2 * DEPTH + 1));
      chk("write_cycles", 64'(wn), 64'(DEPTH));
      chk("read_cycles", 64'(rn), 64'(DEPTH));
      chk("pass", 64'(pass), 64'(ep));
      chk("err_count", 64'(err_count), 64'(ec));
      chk("err_addr", 64'(err_addr), 64'(ea));
      if (hold) begin
         start = 1'b1;
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         chk("restart_one_cycle_done", 64'({done, busy, rf.Write_Reg, rf.W_Addr}), 64'({3'b011, 5'd0}));
         fin = 1'b0;
         for (int i = 0; i < 200 && !fin; i++) begin
            @(negedge clk);
            if (done) fin = 1'b1;
         end
         chk("restart_done_seen", 64'(fin), 64'd1);
         chk("restart_pass", 64'(pass), 64'(ep));
         chk("restart_err_count", 64'(err_count), 64'(ec));
      end else begin
         repeat (3) @(negedge clk);
         chk("done_hold", 64'({done, busy, pass}), 64'({2'b10, ep}));
         chk("done_idle_bus", 64'({rf.Write_Reg, rf.W_Addr, rf.R_Addr_A, rf.R_Addr_B}), 64'd0);
      end
   endtask

   initial begin
      bit fin;
      checks = 0;
      errors = 0;
      start  = 1'b0;
      start2 = 1'b0;
      Reset  = 1'b0;
      clear_faults();

      #3;
      chk("reset_status", 64'({busy, done, pass, err_addr, err_count}), 64'd0);
      chk("reset_bus", 64'({rf.Write_Reg, rf.W_Addr, rf.W_Data, rf.R_Addr_A, rf.R_Addr_B}), 64'd0);
      @(negedge clk);
      Reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_no_activity", 64'({busy, done, rf.Write_Reg}), 64'd0);

      // Clean run
      run_dut(-1, -1, 1'b0);

      // Stuck-at-0 on bit 0 of entry 7
      stuck0[7] = 32'h1;
      run_dut(-1, -1, 1'b0);
      chk("stuck7_err_count", 64'(err_count), 64'd2);
      chk("stuck7_err_addr", 64'(err_addr), 64'd7);
      chk("stuck7_pass", 64'(pass), 64'd0);

      // Fault removed: results clear and pass
      clear_faults();
      run_dut(-1, -1, 1'b0);
      chk("rerun_clean", 64'({pass, err_count, err_addr}), 64'({1'b1, 12'd0}));

      // Stray start pulses at write index 5 and read index 12
      run_dut(5, 12, 1'b0);

      // Asynchronous reset mid-write
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      fin = 1'b0;
      for (int i = 0; i < 40 && !fin; i++) begin
         if (rf.Write_Reg && rf.W_Addr == 5'd10) fin = 1'b1;
         else @(negedge clk);
      end
      chk("reached_w10", 64'(fin), 64'd1);
      #2;
      Reset = 1'b0;
      #1;
      chk("abort_immediate", 64'({rf.Write_Reg, busy, rf.W_Addr}), 64'd0);
      @(negedge clk);
      Reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_stays_idle", 64'({busy, done, rf.Write_Reg}), 64'd0);
      run_dut(-1, -1, 1'b0);

      // Randomized faults; last one also holds start into DONE
      for (int it = 0; it < 4; it++) begin
         int nf;
         clear_faults();
         nf = $urandom_range(1, 3);
         for (int k = 0; k < nf; k++) begin
            int a, b;
            a = $urandom_range(0, DEPTH - 1);
            b = $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) stuck0[a] = stuck0[a] | (32'd1 << b);
            else                           flip[a]   = flip[a]   | (32'd1 << b);
         end
         run_dut(-1, -1, it == 3);
      end
      clear_faults();

      // Wrapping pattern on the second instance
      @(negedge clk);
      start2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start2 = 1'b0;
      fin = 1'b0;
      for (int i = 0; i < 200 && !fin; i++) begin
         if (rf2.Write_Reg && rf2.W_Addr == 5'd1)
            chk("wrap_w_data_addr1", 64'(rf2.W_Data), 64'h0001_0000);
         @(negedge clk);
         if (done2) fin = 1'b1;
      end
      chk("wrap_done_seen", 64'(fin), 64'd1);
      chk("wrap_result", 64'({pass2, err_count2, err_addr2}), 64'({1'b1, 12'd0}));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
